// File: rtl/noc_pkg.sv
// Shared NoC types: merge FSM encoding and default flit geometry.
package noc_pkg;

  localparam int FLIT_WIDTH_DEFAULT = 512;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} merge_state_t;

  typedef struct packed {
    logic                          tail;
    logic [FLIT_WIDTH_DEFAULT-1:0] data;
  } flit_t;

endpackage

// File: rtl/buffer.sv
// Enable register with asynchronous active-low clear.
module Buffer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; prio names the input that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant       = prio;
    if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/flit_merge_2to1.sv
// Two-input flit merge: round-robin per packet, lock until tail, one registered output stage.
module flit_merge_2to1
  import noc_pkg::*;
#(
  parameter int BIT_WIDTH = FLIT_WIDTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     rst_l,
  input  logic [1:0]               in_valid,
  input  logic [1:0][BIT_WIDTH-1:0] in_data,
  input  logic [1:0]               in_tail,
  output logic [1:0]               in_ready,
  output logic                     out_valid,
  output logic [BIT_WIDTH-1:0]     out_data,
  output logic                     out_tail,
  input  logic                     out_ready
);

  merge_state_t state, state_next;
  logic         prio, prio_next;
  logic         arb_grant, arb_valid;
  logic         grant, grant_valid;
  logic         space, xfer, sel_tail;

  rr_arb2 u_arb (
    .req         (in_valid),
    .prio        (prio),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // A locked packet owns the output regardless of either input's valid.
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    unique case (state)
      IDLE: begin
        grant       = arb_grant;
        grant_valid = arb_valid;
      end
      LOCK0: begin
        grant       = 1'b0;
        grant_valid = 1'b1;
      end
      LOCK1: begin
        grant       = 1'b1;
        grant_valid = 1'b1;
      end
      default: begin
        grant       = 1'b0;
        grant_valid = 1'b0;
      end
    endcase
  end

  assign space       = ~out_valid | out_ready;
  assign in_ready[0] = rst_l & space & grant_valid & ~grant;
  assign in_ready[1] = rst_l & space & grant_valid & grant;
  assign xfer        = |(in_valid & in_ready);
  assign sel_tail    = in_tail[grant];

  always_comb begin
    state_next = state;
    prio_next  = prio;
    if (xfer) begin
      if (sel_tail) begin
        state_next = IDLE;
        prio_next  = ~grant;
      end else begin
        state_next = grant ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      prio      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      prio  <= prio_next;
      if (xfer) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  Buffer #(
    .WIDTH (BIT_WIDTH + 1)
  ) u_out_reg (
    .clock (clock),
    .rst_l (rst_l),
    .en    (xfer),
    .d     ({sel_tail, in_data[grant]}),
    .q     ({out_tail, out_data})
  );

endmodule
